// File: rtl/adc_sample_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_seq_pkg
// Purpose  : Shared types and constants for the ADC sample sequencer.
// Revision : 1.0  initial release
// ============================================================================
package adc_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_ARMED   = 2'd1,
        SEQ_CONVERT = 2'd2
    } seq_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Accumulator must hold 2^max_log2 full-scale samples without wrapping.
    function automatic int acc_width(input int adc_w, input int max_log2);
        return adc_w + max_log2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sample_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_sequencer_if
// Purpose  : Control, reader-handshake and sample-output bundle of the sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface adc_sample_sequencer_if #(
    parameter int ADC_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 16
);
    logic                    enable;
    logic [PERIOD_WIDTH-1:0] period;
    logic [2:0]              log2_avg;
    logic                    clear_err;
    logic                    conv_start;
    logic                    adc_valid;
    logic [ADC_WIDTH-1:0]    adc_data;
    logic [ADC_WIDTH-1:0]    sample_data;
    logic                    sample_valid;
    logic                    sample_ready;
    logic                    overrun_err;
    logic                    timeout_err;
    logic                    drop_err;
    logic                    busy;

    modport master (
        input  enable, period, log2_avg, clear_err, adc_valid, adc_data, sample_ready,
        output conv_start, sample_data, sample_valid, overrun_err, timeout_err, drop_err, busy
    );

    modport slave (
        output enable, period, log2_avg, clear_err, adc_valid, adc_data, sample_ready,
        input  conv_start, sample_data, sample_valid, overrun_err, timeout_err, drop_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/adc_sample_sequencer_period_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : period_tick_gen
// Purpose  : Modulo-P counter with synchronous clear; tick at count P-1.
// Revision : 1.0  initial release
// ============================================================================
module period_tick_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             sresetn,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_period,
    output logic             o_tick
);
    logic [WIDTH-1:0] r_count;

    // >= keeps the counter bounded if the period is re-latched smaller mid-count.
    assign o_tick = !i_clr && (r_count >= (i_period - WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (!sresetn || i_clr) begin
            r_count <= '0;
        end else if (o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + WIDTH'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/adc_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_sequencer
// Purpose  : Periodic conversion scheduler with 2^N averaging and supervision.
// Revision : 1.0  initial release
// ============================================================================
module adc_sample_sequencer
    import adc_seq_pkg::*;
#(
    parameter int ADC_WIDTH      = 16,
    parameter int PERIOD_WIDTH   = 16,
    parameter int MAX_LOG2_AVG   = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   sresetn,
    adc_sample_sequencer_if.master bus
);
    localparam int c_ACC_W = acc_width(ADC_WIDTH, MAX_LOG2_AVG);
    localparam int c_CNT_W = MAX_LOG2_AVG + 1;
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] c_ST_IDLE    = SEQ_IDLE;
    localparam logic [1:0] c_ST_ARMED   = SEQ_ARMED;
    localparam logic [1:0] c_ST_CONVERT = SEQ_CONVERT;

    logic [1:0]              r_state;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [2:0]              r_log2;
    logic [c_ACC_W-1:0]      r_acc;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_TMO_W-1:0]      r_tmo;
    logic                    r_conv_start;
    logic                    r_sample_valid;
    logic [ADC_WIDTH-1:0]    r_sample_data;
    logic                    r_overrun;
    logic                    r_timeout;
    logic                    r_drop;

    logic                    w_tick;
    logic                    w_tick_clr;
    logic [PERIOD_WIDTH-1:0] w_period_eff;
    logic [2:0]              w_log2_eff;
    logic [c_ACC_W-1:0]      w_acc_sum;
    logic [c_CNT_W-1:0]      w_cnt_inc;
    logic                    w_block_done;
    logic [ADC_WIDTH-1:0]    w_result_data;
    logic                    w_convert_active;
    logic                    w_result;
    logic                    w_tmo_hit;
    logic                    w_overrun_set;
    logic                    w_timeout_set;
    logic                    w_drop_set;

    assign w_period_eff = (bus.period < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : bus.period;
    assign w_log2_eff   = (int'(bus.log2_avg) > MAX_LOG2_AVG) ? 3'(MAX_LOG2_AVG) : bus.log2_avg;

    // Dropping enable takes priority over everything, so the tick is held off too.
    assign w_tick_clr = (r_state == c_ST_IDLE) || !bus.enable;

    period_tick_gen #(
        .WIDTH (PERIOD_WIDTH)
    ) u_tick_gen (
        .clk      (clk),
        .sresetn  (sresetn),
        .i_clr    (w_tick_clr),
        .i_period (r_period),
        .o_tick   (w_tick)
    );

    assign w_acc_sum        = r_acc + c_ACC_W'(bus.adc_data);
    assign w_cnt_inc        = r_cnt + c_CNT_W'(1);
    assign w_block_done     = (w_cnt_inc == (c_CNT_W'(1) << r_log2));
    assign w_result_data    = ADC_WIDTH'(w_acc_sum >> r_log2);
    assign w_convert_active = (r_state == c_ST_CONVERT) && bus.enable;
    assign w_result         = w_convert_active && bus.adc_valid && w_block_done;
    assign w_tmo_hit        = (r_tmo == c_TMO_W'(TIMEOUT_CYCLES));
    assign w_overrun_set    = w_convert_active && w_tick;
    assign w_timeout_set    = w_convert_active && !bus.adc_valid && w_tmo_hit;
    assign w_drop_set       = w_result && r_sample_valid && !bus.sample_ready;

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_state      <= c_ST_IDLE;
            r_period     <= '0;
            r_log2       <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_tmo        <= '0;
            r_conv_start <= 1'b0;
        end else begin
            r_conv_start <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.enable) begin
                        r_period <= w_period_eff;
                        r_log2   <= w_log2_eff;
                        r_state  <= c_ST_ARMED;
                    end
                end
                c_ST_ARMED: begin
                    if (!bus.enable) begin
                        r_state <= c_ST_IDLE;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else if (w_tick) begin
                        r_conv_start <= 1'b1;
                        r_tmo        <= '0;
                        r_state      <= c_ST_CONVERT;
                    end
                end
                c_ST_CONVERT: begin
                    if (!bus.enable) begin
                        r_state <= c_ST_IDLE;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else if (bus.adc_valid) begin
                        r_state <= c_ST_ARMED;
                        if (w_block_done) begin
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_period <= w_period_eff;
                            r_log2   <= w_log2_eff;
                        end else begin
                            r_acc <= w_acc_sum;
                            r_cnt <= w_cnt_inc;
                        end
                    end else if (w_tmo_hit) begin
                        r_state <= c_ST_ARMED;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // A result coinciding with an accepting handshake replaces the held one.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_sample_valid <= 1'b0;
            r_sample_data  <= '0;
            r_overrun      <= 1'b0;
            r_timeout      <= 1'b0;
            r_drop         <= 1'b0;
        end else begin
            if (w_result && (!r_sample_valid || bus.sample_ready)) begin
                r_sample_data  <= w_result_data;
                r_sample_valid <= 1'b1;
            end else if (r_sample_valid && bus.sample_ready) begin
                r_sample_valid <= 1'b0;
            end
            r_overrun <= w_overrun_set | (r_overrun & ~bus.clear_err);
            r_timeout <= w_timeout_set | (r_timeout & ~bus.clear_err);
            r_drop    <= w_drop_set    | (r_drop    & ~bus.clear_err);
        end
    end

    assign bus.conv_start   = r_conv_start;
    assign bus.sample_valid = r_sample_valid;
    assign bus.sample_data  = r_sample_data;
    assign bus.overrun_err  = r_overrun;
    assign bus.timeout_err  = r_timeout;
    assign bus.drop_err     = r_drop;
    assign bus.busy         = (r_state != c_ST_IDLE);
endmodule
`default_nettype wire

// File: doc/adc_sample_sequencer.md
# adc_sample_sequencer

Conversion scheduler for the AD4008 read core. Issues conversion-start pulses to the reader at a programmable period, collects its `new_data_flag`/`amplified_data` results, and averages 2^N samples. Presents each averaged sample on a single-entry valid/ready output, with timeout and overflow supervision. Sits between the reader core and downstream sample consumers (FIFO/register bank).

## Interface
Parameters:
- `ADC_WIDTH`, 16, reader sample width
- `PERIOD_WIDTH`, 16, width of period register
- `MAX_LOG2_AVG`, 4, maximum averaging exponent
- `TIMEOUT_CYCLES`, 255, max clk cycles from `conv_start` to `adc_valid`

Ports:
- `clk` in 1: system clock; single clock domain
- `sresetn` in 1: reset, synchronous, active-low
- `enable` in 1: run sequencer
- `period` in PERIOD_WIDTH: clk cycles between conversion starts
- `log2_avg` in 3: averaging exponent N
- `clear_err` in 1: clears sticky errors
- `conv_start` out 1: one-cycle trigger to reader
- `adc_valid` in 1: reader `new_data_flag`
- `adc_data` in ADC_WIDTH: reader `amplified_data`, unsigned
- `sample_data` out ADC_WIDTH: averaged result
- `sample_valid` out 1: result valid
- `sample_ready` in 1: consumer accepts
- `overrun_err` out 1: sticky
- `timeout_err` out 1: sticky
- `drop_err` out 1: sticky
- `busy` out 1: state != IDLE

## Operation
- States: IDLE, ARMED, CONVERT.
- IDLE:
  - On `enable`, latch `period` and `log2_avg`; go to ARMED.
  - Effective period is `max(period, 2)`; effective N is `min(log2_avg, MAX_LOG2_AVG)`.
- Tick counter: runs only outside IDLE, counts 0..P-1 and asserts tick at P-1. First tick occurs P cycles after leaving IDLE.
- ARMED: on tick, pulse `conv_start` and go to CONVERT. Clear the timeout counter.
- CONVERT:
  - On `adc_valid`: `acc += adc_data` (acc width ADC_WIDTH+MAX_LOG2_AVG, unsigned), `cnt++`, go to ARMED.
  - If `cnt` reaches 2^N: result = acc >> N (truncating); clear `acc`/`cnt`; re-latch `period`/`log2_avg` for the next block.
  - Tick while in CONVERT: no `conv_start`, set `overrun_err`, stay in CONVERT.
  - Timeout counter reaching TIMEOUT_CYCLES without `adc_valid`: set `timeout_err`, discard `acc`/`cnt`, go to ARMED.
- `adc_valid` outside CONVERT is ignored.
- Output register:
  - Result loads `sample_data` and sets `sample_valid`.
  - `sample_valid && sample_ready` clears `sample_valid`.
  - Result arriving while `sample_valid` is held and `sample_ready` is low: result dropped, `drop_err` set, held data unchanged.
  - Result arriving in the same cycle as an accepting handshake: new result loads, `sample_valid` stays 1.
- `enable` low in any non-IDLE state: next cycle goes to IDLE; `acc`/`cnt`/tick counter cleared. Output register and errors retained.
- `clear_err` clears all sticky errors. If an error is set in the same cycle as `clear_err`, set wins.

## Timing
- All outputs reset to 0: `conv_start`, `sample_valid`, `sample_data`, errors, `busy`. State resets to IDLE; counters and `acc` to 0.
- `conv_start` is registered, high for exactly 1 cycle, in the cycle after tick.
- `sample_valid` rises 1 cycle after the `adc_valid` that completes the block.
- Conversion-start spacing is exactly P cycles absent overrun.
- `busy` goes high 1 cycle after `enable` rises and low 1 cycle after `enable` falls.
- Reset mid-CONVERT: everything reset; a later stray `adc_valid` is ignored.

## Structure
- Package `adc_seq_pkg`:
  - state enum `seq_state_t`
  - `ACC_WIDTH` localparam function
  - default `TIMEOUT_CYCLES`
- Sub-module `period_tick_gen`: loadable modulo-P counter with sync clear and a 1-cycle tick output.
- Top level holds the FSM, accumulator, timeout counter and output register.

## Test plan
- `period`=10, `log2_avg`=0, emulator returns 0xAAAA -> `conv_start` every 10 cycles; each result 0xAAAA, `sample_valid` 1 cycle after `adc_valid`.
- `log2_avg`=2, samples 0x0010, 0x0020, 0x0030, 0x0041 -> one result 0x0028 after the 4th sample; no output before.
- `sample_ready` held 0 across two results -> first result 0x00F0 held, `drop_err`=1; asserting `sample_ready` then delivers 0x00F0.
- No `adc_valid` after `conv_start` -> `timeout_err`=1 after 255 cycles; next `conv_start` occurs on the following tick; partial sum discarded.
- `period`=2 with reader latency >2 cycles -> `overrun_err`=1, no `conv_start` while in CONVERT; `clear_err` then clears it.
- `enable` dropped mid-CONVERT, then `sresetn` low for 1 cycle -> `busy`=0, all outputs 0, late `adc_valid` produces no result.
